pc_sequencer: RTL

//  Fetch/issue sequencer for the 2-stage (FETCH -> EX/WB) CPU core. Owns
//  PC_FETCH, tracks the PC of the instruction in EX, and squashes the

---
 rtl/pc_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Fetch/issue sequencer for a 2-stage (FETCH -> EX/WB) core. Owns the fetch
//   PC, tracks the PC of the instruction in EX, squashes the wrong-path fetch
//   after a taken branch/jump, holds for multi-cycle EX ops, implements
//   halt/resume and counts retired instructions.
//
// Ports
//   clk          in   1     clock, all state on posedge
//   rst_n        in   1     synchronous active-low reset
//   stall_req    in   1     EX instruction needs another cycle
//   redirect_EX  in   1     EX instruction is a taken branch/jump
//   target_EX    in   PC_W  redirect target (word address)
//   halt_EX      in   1     EX instruction is a halt
//   resume       in   1     pulse, leave HALT
//   pc_fetch     out  PC_W  address presented to instruction RAM
//   pc_ex        out  PC_W  PC of the instruction in EX
//   ex_valid     out  1     EX instruction is real (0 = bubble)
//   ex_hold      out  1     combinational: stall_req & ex_valid
//   halted       out  1     1 while halted
//   instret      out  32    retired-instruction count
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned          PC_W     = 12,
    parameter logic [PC_W-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_req,
    input  logic            redirect_EX,
    input  logic [PC_W-1:0] target_EX,
    input  logic            halt_EX,
    input  logic            resume,
    output logic [PC_W-1:0] pc_fetch,
    output logic [PC_W-1:0] pc_ex,
    output logic            ex_valid,
    output logic            ex_hold,
    output logic            halted,
    output logic [31:0]     instret
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALT   = 2'd2
    } state_e;

    state_e             state_q,    state_d;
    logic [PC_W-1:0]    pc_fetch_q, pc_fetch_d;
    logic [PC_W-1:0]    pc_ex_q,    pc_ex_d;
    logic               ex_valid_q, ex_valid_d;
    logic               halted_q,   halted_d;
    logic [CNT_W-1:0]   instret_q,  instret_d;

    // Sequential fetch address; wraps modulo 2^PC_W.
    logic [PC_W-1:0]    pc_seq;
    assign pc_seq = pc_fetch_q + PC_W'(1);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_fetch_q <= RESET_PC;
            pc_ex_q    <= RESET_PC;
            ex_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_fetch_q <= pc_fetch_d;
            pc_ex_q    <= pc_ex_d;
            ex_valid_q <= ex_valid_d;
            halted_q   <= halted_d;
            instret_q  <= instret_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        pc_fetch_d = pc_fetch_q;
        pc_ex_d    = pc_ex_q;
        ex_valid_d = ex_valid_q;
        halted_d   = halted_q;
        instret_d  = instret_q;

        unique case (state_q)
            ST_RUN: begin
                if (!ex_valid_q) begin
                    // Bubble in EX: just advance the pipeline.
                    pc_ex_d    = pc_fetch_q;
                    pc_fetch_d = pc_seq;
                    ex_valid_d = 1'b1;
                end else if (stall_req) begin
                    // Multi-cycle EX op: everything holds, redirect/halt wait.
                end else begin
                    // Instruction leaves EX this cycle, so it retires.
                    instret_d = instret_q + CNT_W'(1);
                    if (halt_EX) begin
                        // pc_fetch already points at halt+1; keep it.
                        ex_valid_d = 1'b0;
                        halted_d   = 1'b1;
                        state_d    = ST_HALT;
                    end else if (redirect_EX) begin
                        // Drop the wrong-path fetch: one bubble.
                        pc_fetch_d = target_EX;
                        ex_valid_d = 1'b0;
                        state_d    = ST_SQUASH;
                    end else begin
                        pc_ex_d    = pc_fetch_q;
                        pc_fetch_d = pc_seq;
                        ex_valid_d = 1'b1;
                    end
                end
            end

            ST_SQUASH: begin
                // Target instruction is being fetched; move it into EX.
                pc_ex_d    = pc_fetch_q;
                pc_fetch_d = pc_seq;
                ex_valid_d = 1'b1;
                state_d    = ST_RUN;
            end

            ST_HALT: begin
                ex_valid_d = 1'b0;
                if (resume) begin
                    pc_ex_d    = pc_fetch_q;
                    pc_fetch_d = pc_seq;
                    ex_valid_d = 1'b1;
                    halted_d   = 1'b0;
                    state_d    = ST_RUN;
                end
            end

            default: begin
                state_d    = ST_RUN;
                ex_valid_d = 1'b0;
                halted_d   = 1'b0;
            end
        endcase
    end

    assign pc_fetch = pc_fetch_q;
    assign pc_ex    = pc_ex_q;
    assign ex_valid = ex_valid_q;
    assign halted   = halted_q;
    assign instret  = instret_q;

    // CPU keeps instruction_EX while a real instruction is stalling.
    assign ex_hold  = stall_req & ex_valid_q;

endmodule
